// File: rtl/fpu_pkg.sv
// Shared definitions for the FPU request dispatcher: op-codes, the
// dispatcher FSM state enum and the queued request payload.
// Configuration macro FPU_DISPATCH_DIVZERO_EN is consumed by fpu_dispatch.
package fpu_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned OP_W   = 3;

  localparam logic [OP_W-1:0] OP_ADD = OP_W'(0);
  localparam logic [OP_W-1:0] OP_SUB = OP_W'(1);
  localparam logic [OP_W-1:0] OP_MUL = OP_W'(2);
  localparam logic [OP_W-1:0] OP_DIV = OP_W'(3);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  // Operation payload held in the request FIFO (tag is appended by the top).
  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } fpu_req_t;

  // Codes above OP_DIV are not supported by the FPU.
  function automatic logic op_legal(input logic [OP_W-1:0] op);
    return (op <= OP_DIV);
  endfunction

endpackage

// File: rtl/fpu_req_fifo.sv
// Request FIFO for the FPU dispatcher.
// Ports: clk, rst (sync, active-high); push_i/data_i write side;
// pop_i read side; head_c_o shows the oldest entry; full_c_o/empty_c_o status.
// DEPTH must be a power of two (pointers wrap by natural overflow).
module fpu_req_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_c_o,
  output logic             full_c_o,
  output logic             empty_c_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q;
  logic [PTR_W-1:0] rd_q;
  logic [CNT_W-1:0] cnt_q;
  logic             do_push;
  logic             do_pop;

  assign full_c_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_c_o = (cnt_q == '0);
  assign do_push   = push_i && !full_c_o;
  assign do_pop    = pop_i && !empty_c_o;
  assign head_c_o  = mem_q[rd_q];

  // Pointers and occupancy; simultaneous push+pop leaves the count unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + PTR_W'(1);
      if (do_pop)  rd_q <= rd_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage needs no reset; occupancy alone defines validity.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/fpu_dispatch.sv
// FPU dispatcher: queues tagged requests, issues them one at a time to a
// 1-cycle-latency FPU, waits for its result (with timeout) and returns an
// in-order tagged response.
// Ports: clk, rst (sync, active-high); req_* request handshake and payload;
// fpu_* operand/op drive and result/valid return; rsp_* response handshake.
// Macro FPU_DISPATCH_DIVZERO_EN: divide by zero is answered with an error
// response without being issued to the FPU.
module fpu_dispatch
  import fpu_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TAG_W   = 4,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [31:0]       req_a,
  input  logic [31:0]       req_b,
  input  logic [TAG_W-1:0]  req_tag,
  output logic [31:0]       fpu_operand_a,
  output logic [31:0]       fpu_operand_b,
  output logic [2:0]        fpu_operation,
  input  logic [31:0]       fpu_result,
  input  logic              fpu_valid,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_result,
  output logic [TAG_W-1:0]  rsp_tag,
  output logic              rsp_err
);

  localparam int unsigned ENT_W = $bits(fpu_req_t) + TAG_W;
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  fpu_req_t           in_req;
  fpu_req_t           head_req;
  logic [TAG_W-1:0]   head_tag;
  logic [ENT_W-1:0]   fifo_head_c;
  logic               fifo_full_c;
  logic               fifo_empty_c;
  logic               push_c;
  logic               pop_c;
  logic               bypass_c;

  state_e             state_q, state_d;
  logic [31:0]        opa_q, opa_d;
  logic [31:0]        opb_q, opb_d;
  logic [2:0]         fop_q, fop_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [CNT_W-1:0]   wcnt_q, wcnt_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [31:0]        rsp_result_q, rsp_result_d;
  logic [TAG_W-1:0]   rsp_tag_q, rsp_tag_d;
  logic               rsp_err_q, rsp_err_d;

  // Ready is forced low while reset is held so nothing enters the queue.
  assign req_ready = !rst && !fifo_full_c;
  assign push_c    = req_valid && req_ready;

  assign in_req.op = req_op;
  assign in_req.a  = req_a;
  assign in_req.b  = req_b;

  fpu_req_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENT_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push_i    (push_c),
    .data_i    ({req_tag, in_req}),
    .pop_i     (pop_c),
    .head_c_o  (fifo_head_c),
    .full_c_o  (fifo_full_c),
    .empty_c_o (fifo_empty_c)
  );

  assign {head_tag, head_req} = fifo_head_c;

  // Requests answered locally with an error instead of going to the FPU.
`ifdef FPU_DISPATCH_DIVZERO_EN
  assign bypass_c = !op_legal(head_req.op) ||
                    ((head_req.op == OP_DIV) && (head_req.b == '0));
`else
  assign bypass_c = !op_legal(head_req.op);
`endif

  // Next-state and datapath: fpu_* registers only change on a real issue.
  always_comb begin
    state_d      = state_q;
    opa_d        = opa_q;
    opb_d        = opb_q;
    fop_d        = fop_q;
    tag_d        = tag_q;
    wcnt_d       = wcnt_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_tag_d    = rsp_tag_q;
    rsp_err_d    = rsp_err_q;
    pop_c        = 1'b0;

    case (state_q)
      IDLE: begin
        if (!fifo_empty_c) begin
          pop_c = 1'b1;
          tag_d = head_tag;
          if (bypass_c) begin
            rsp_valid_d  = 1'b1;
            rsp_result_d = '0;
            rsp_tag_d    = head_tag;
            rsp_err_d    = 1'b1;
            state_d      = RESP;
          end else begin
            opa_d   = head_req.a;
            opb_d   = head_req.b;
            fop_d   = head_req.op;
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        wcnt_d  = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (fpu_valid) begin
          rsp_valid_d  = 1'b1;
          rsp_result_d = fpu_result;
          rsp_tag_d    = tag_q;
          rsp_err_d    = 1'b0;
          state_d      = RESP;
        end else if (wcnt_q == CNT_W'(TIMEOUT - 1)) begin
          // Last permitted wait cycle elapsed without a result.
          rsp_valid_d  = 1'b1;
          rsp_result_d = '0;
          rsp_tag_d    = tag_q;
          rsp_err_d    = 1'b1;
          state_d      = RESP;
        end else begin
          wcnt_d = wcnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      opa_q        <= '0;
      opb_q        <= '0;
      fop_q        <= '0;
      tag_q        <= '0;
      wcnt_q       <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_tag_q    <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      opa_q        <= opa_d;
      opb_q        <= opb_d;
      fop_q        <= fop_d;
      tag_q        <= tag_d;
      wcnt_q       <= wcnt_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_tag_q    <= rsp_tag_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  assign fpu_operand_a = opa_q;
  assign fpu_operand_b = opb_q;
  assign fpu_operation = fop_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_result    = rsp_result_q;
  assign rsp_tag       = rsp_tag_q;
  assign rsp_err       = rsp_err_q;

endmodule

// File: tb/tb_fpu_dispatch.sv
// Randomised self-checking bench for fpu_dispatch with an integer FPU stub
// and a queue-based reference model of expected responses.
module tb_fpu_dispatch;

  localparam int unsigned DEPTH   = 4;
  localparam int unsigned TAG_W   = 4;
  localparam int unsigned TIMEOUT = 15;

  logic             clk;
  logic             rst;
  logic             req_valid;
  logic             req_ready;
  logic [2:0]       req_op;
  logic [31:0]      req_a;
  logic [31:0]      req_b;
  logic [TAG_W-1:0] req_tag;
  logic [31:0]      fpu_operand_a;
  logic [31:0]      fpu_operand_b;
  logic [2:0]       fpu_operation;
  logic [31:0]      fpu_result;
  logic             fpu_valid;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [31:0]      rsp_result;
  logic [TAG_W-1:0] rsp_tag;
  logic             rsp_err;

  fpu_dispatch #(
    .DEPTH   (DEPTH),
    .TAG_W   (TAG_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_op        (req_op),
    .req_a         (req_a),
    .req_b         (req_b),
    .req_tag       (req_tag),
    .fpu_operand_a (fpu_operand_a),
    .fpu_operand_b (fpu_operand_b),
    .fpu_operation (fpu_operation),
    .fpu_result    (fpu_result),
    .fpu_valid     (fpu_valid),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_result    (rsp_result),
    .rsp_tag       (rsp_tag),
    .rsp_err       (rsp_err)
  );

  typedef struct {
    logic [31:0]      res;
    logic [TAG_W-1:0] tag;
    logic             err;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   acc_cyc  = 0;
  int   rdy_mode = 1;   // 0: hold low, 1: hold high, 2: random
  bit   fpu_dead = 0;   // FPU never answers
  bit   fpu_rand = 0;   // FPU answers after a random delay
  int   lat;
  int   cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Integer stand-in for the FPU arithmetic.
  function automatic logic [31:0] fpu_fn(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a * b;
      3'd3:    return (b == 0) ? 32'd0 : a / b;
      default: return 32'd0;
    endcase
  endfunction

  // Expected response for a request accepted under the current FPU behaviour.
  function automatic exp_t model(input logic [2:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input logic [TAG_W-1:0] tag);
    exp_t e;
    e.tag = tag;
    e.res = 32'd0;
    e.err = 1'b1;
    if (op > 3) return e;
`ifdef FPU_DISPATCH_DIVZERO_EN
    if (op == 3 && b == 0) return e;
`endif
    if (fpu_dead) return e;
    e.res = fpu_fn(op, a, b);
    e.err = 1'b0;
    return e;
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  always @(posedge clk) begin
    if (rst) fpu_result <= 32'd0;
    else     fpu_result <= fpu_fn(fpu_operation, fpu_operand_a, fpu_operand_b);
  end

  // fpu_valid and rsp_ready drivers, updated just after each rising edge.
  initial begin
    int zeros;
    zeros     = 0;
    fpu_valid = 1'b0;
    rsp_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (fpu_dead) begin
        fpu_valid = 1'b0;
      end else if (fpu_rand) begin
        fpu_valid = (zeros >= 3) ? 1'b1 : ($urandom_range(2, 0) != 0);
        zeros     = fpu_valid ? 0 : zeros + 1;
      end else begin
        fpu_valid = 1'b1;
      end
      case (rdy_mode)
        0:       rsp_ready = 1'b0;
        1:       rsp_ready = 1'b1;
        default: rsp_ready = 1'($urandom_range(1, 0));
      endcase
    end
  end

  // Monitor: handshakes observed mid-cycle, responses checked against the model.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      exp_q.delete();
    end else begin
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_rsp", 32'd1, 32'd0);
        end else begin
          check("rsp_result", rsp_result, exp_q[0].res);
          check("rsp_tag", 32'(rsp_tag), 32'(exp_q[0].tag));
          check("rsp_err", 32'(rsp_err), 32'(exp_q[0].err));
          if (rsp_ready) void'(exp_q.pop_front());
        end
      end
      if (req_valid && req_ready) begin
        exp_q.push_back(model(req_op, req_a, req_b, req_tag));
        acc_cyc = cyc;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request and hold it until accepted.
  task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [TAG_W-1:0] tag);
    bit ok;
    int tries;
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    req_tag   = tag;
    tries     = 0;
    do begin
      @(negedge clk);
      ok = req_ready;
      tries++;
      tick();
    end while (!ok && tries < 500);
    if (!ok) check("req_accept_timeout", 32'd0, 32'd1);
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int l);
    int n;
    n = 0;
    l = -1;
    do begin
      @(negedge clk);
      n++;
    end while (!rsp_valid && n < 200);
    if (rsp_valid) l = cyc - acc_cyc;
    else check("rsp_wait_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_reset_values(input string pfx);
    check({pfx, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({pfx, "_rsp_result"}, rsp_result, 32'd0);
    check({pfx, "_rsp_tag"}, 32'(rsp_tag), 32'd0);
    check({pfx, "_rsp_err"}, 32'(rsp_err), 32'd0);
    check({pfx, "_fpu_a"}, fpu_operand_a, 32'd0);
    check({pfx, "_fpu_b"}, fpu_operand_b, 32'd0);
    check({pfx, "_fpu_op"}, 32'(fpu_operation), 32'd0);
    check({pfx, "_req_ready"}, 32'(req_ready), 32'd0);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(exp_q.size()), 32'd0);
    tick();
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    req_tag   = '0;

    // Reset values, then ready on the first free cycle.
    tick();
    @(negedge clk);
    check_reset_values("rst");
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", 32'(req_ready), 32'd1);
    tick();

    // 3 + 4, tag 5: response four cycles after acceptance.
    send(3'd0, 32'd3, 32'd4, 4'd5);
    wait_rsp(lat);
    check("add_latency", 32'(lat), 32'd4);
    check("add_result", rsp_result, 32'd7);
    check("add_tag", 32'(rsp_tag), 32'd5);
    check("add_err", 32'(rsp_err), 32'd0);
    tick();

    // Back-pressure: one in flight plus DEPTH queued fills everything.
    rdy_mode = 0;
    for (int i = 0; i <= int'(DEPTH); i++) send(3'd0, 32'(i), 32'd100, 4'(i));
    @(negedge clk);
    check("full_ready_low", 32'(req_ready), 32'd0);
    repeat (3) tick();
    @(negedge clk);
    check("full_ready_held", 32'(req_ready), 32'd0);
    tick();
    rdy_mode = 1;
    drain("bp_drain_left");

    // FPU silent: error after TIMEOUT wait cycles, then normal service.
    fpu_dead = 1;
    send(3'd0, 32'd10, 32'd20, 4'd7);
    wait_rsp(lat);
    check("to_latency", 32'(lat), 32'(TIMEOUT + 3));
    check("to_result", rsp_result, 32'd0);
    check("to_err", 32'(rsp_err), 32'd1);
    check("to_tag", 32'(rsp_tag), 32'd7);
    tick();
    fpu_dead = 0;
    send(3'd1, 32'd50, 32'd8, 4'd8);
    wait_rsp(lat);
    check("after_to_result", rsp_result, 32'd42);
    check("after_to_err", 32'(rsp_err), 32'd0);
    tick();

    // Illegal op leaves the FPU drive untouched.
    send(3'd2, 32'd6, 32'd7, 4'd2);
    wait_rsp(lat);
    check("mul_result", rsp_result, 32'd42);
    tick();
    send(3'd6, 32'd1, 32'd2, 4'd9);
    wait_rsp(lat);
    check("ill_err", 32'(rsp_err), 32'd1);
    check("ill_result", rsp_result, 32'd0);
    check("ill_tag", 32'(rsp_tag), 32'd9);
    check("ill_fpu_op", 32'(fpu_operation), 32'd2);
    check("ill_fpu_a", fpu_operand_a, 32'd6);
    tick();

    // Divide by zero.
    send(3'd3, 32'd8, 32'd0, 4'd4);
    wait_rsp(lat);
`ifdef FPU_DISPATCH_DIVZERO_EN
    check("div0_err", 32'(rsp_err), 32'd1);
    check("div0_result", rsp_result, 32'd0);
    check("div0_no_issue", 32'(fpu_operation), 32'd2);
`else
    check("div0_err", 32'(rsp_err), 32'd0);
    check("div0_result", rsp_result, 32'd0);
    check("div0_issued", 32'(fpu_operation), 32'd3);
`endif
    tick();

    // Reset while waiting with two requests queued.
    fpu_dead = 1;
    send(3'd0, 32'd1, 32'd1, 4'd1);
    send(3'd0, 32'd2, 32'd2, 4'd2);
    send(3'd0, 32'd3, 32'd3, 4'd3);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    @(negedge clk);
    check_reset_values("midrst");
    tick();
    rst      = 1'b0;
    fpu_dead = 0;
    @(negedge clk);
    check("midrst_ready", 32'(req_ready), 32'd1);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      @(negedge clk);
      if (rsp_valid) cnt++;
    end
    check("midrst_no_rsp", 32'(cnt), 32'd0);
    tick();
    send(3'd0, 32'd100, 32'd23, 4'd6);
    wait_rsp(lat);
    check("midrst_new_result", rsp_result, 32'd123);
    check("midrst_new_tag", 32'(rsp_tag), 32'd6);
    tick();

    // Random traffic with random FPU delay and response back-pressure.
    fpu_rand = 1;
    rdy_mode = 2;
    for (int i = 0; i < 300; i++) begin
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      op = ($urandom_range(7, 0) < 6) ? 3'($urandom_range(3, 0)) : 3'($urandom_range(7, 4));
      a  = ($urandom_range(1, 0) != 0) ? $urandom : 32'($urandom_range(1000, 0));
      b  = ($urandom_range(7, 0) == 0) ? 32'd0 : 32'($urandom_range(1000, 1));
      send(op, a, b, 4'($urandom_range(15, 0)));
      repeat ($urandom_range(2, 0)) tick();
    end
    rdy_mode = 1;
    drain("rand_drain_left");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
